mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter: address width,
// the reset value of the fetched instruction, FSM state encodings, parameter
// defaults, the winner id type and the latched request record.
package mem_arbiter_pkg;

  localparam int          PC_WIDTH        = 16;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam int RAM_LATENCY_DEFAULT  = 1;
  localparam int STARVE_LIMIT_DEFAULT = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic {
    WIN_MEM = 1'b0,
    WIN_IF  = 1'b1
  } winner_e;

  typedef struct packed {
    logic                we;
    logic [PC_WIDTH-1:0] addr;
    logic [31:0]         wdata;
  } acc_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Requester-side bundle of the arbiter: the instruction-fetch port
// (if_req/if_addr/if_flush -> if_ack/if_rdata) and the data port
// (mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata).
//   master : CPU side, drives requests, receives acks and read data
//   slave  : arbiter side
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                if_req;
  logic [PC_WIDTH-1:0] if_addr;
  logic                if_flush;
  logic                if_ack;
  logic [31:0]         if_rdata;

  logic                mem_req;
  logic                mem_we;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [31:0]         mem_wdata;
  logic                mem_ack;
  logic [31:0]         mem_rdata;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata,
    output if_ack, if_rdata, mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single-port RAM between instruction fetch and the data stage.
// MEM normally wins a tie; IF wins once it has lost STARVE_LIMIT decisions in
// a row. Every access takes RAM_LATENCY+2 cycles from request to ack.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   bus        requester bundle (slave modport)
//   ram_we     one-cycle write strobe to the RAM
//   ram_addr   RAM address (registered)
//   ram_wdata  RAM write data (registered)
//   ram_q      RAM read data, valid RAM_LATENCY cycles after ram_addr
//   busy       high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here
// ACCESS | address on the RAM, latency counter running
// RESP   | read data arriving; ack/rdata registered on exit
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY  = RAM_LATENCY_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus,
  output logic                ram_we,
  output logic [PC_WIDTH-1:0] ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_q,
  output logic                busy
);

  localparam int             SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [1:0]     LAT_LOAD   = 2'(RAM_LATENCY - 1);

  logic [1:0]    state;
  logic [1:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  winner_e       win;
  acc_req_t      acc;
  logic          flush_q;
  logic          if_ack_q;
  logic          mem_ack_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   mem_rdata_q;

  logic if_elig;
  logic grant;
  logic grant_if;
  logic if_drop;

  always_comb begin
    // A flush seen while idle makes the pending fetch stale.
    if_elig  = bus.if_req & ~bus.if_flush;
    grant    = if_elig | bus.mem_req;
    grant_if = if_elig & (~bus.mem_req | (starve_cnt >= STARVE_MAX));
    // Flush may arrive in any cycle of an IF access, including RESP itself.
    if_drop  = flush_q | bus.if_flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lat_cnt     <= 2'd0;
      starve_cnt  <= '0;
      win         <= WIN_MEM;
      acc         <= '0;
      flush_q     <= 1'b0;
      ram_we      <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= NOP_INSTRUCTION;
      mem_rdata_q <= 32'd0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state   <= ST_ACCESS;
            lat_cnt <= LAT_LOAD;
            flush_q <= 1'b0;
            if (grant_if) begin
              win        <= WIN_IF;
              acc.we     <= 1'b0;
              acc.addr   <= bus.if_addr;
              starve_cnt <= '0;
            end else begin
              win       <= WIN_MEM;
              acc.we    <= bus.mem_we;
              acc.addr  <= bus.mem_addr;
              acc.wdata <= bus.mem_wdata;
              ram_we    <= bus.mem_we;
              if (bus.if_req && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        ST_ACCESS: begin
          if ((win == WIN_IF) && bus.if_flush) begin
            flush_q <= 1'b1;
          end
          if (lat_cnt == 2'd0) begin
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (win == WIN_IF) begin
            if (!if_drop) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= ram_q;
            end
          end else begin
            mem_ack_q <= 1'b1;
            if (!acc.we) begin
              mem_rdata_q <= ram_q;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr      = acc.addr;
  assign ram_wdata     = acc.wdata;
  assign busy          = (state != ST_IDLE);
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a registered one-cycle RAM model.
// Stimulus pushes expected acks into a scoreboard queue; a monitor pops and
// compares whenever an ack appears. Requesters drop req in the ack cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                ram_we;
  logic [PC_WIDTH-1:0] ram_addr;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_q;
  logic                busy;

  mem_arbiter_if bus ();

  mem_arbiter #(.RAM_LATENCY(1), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];

  function automatic logic [31:0] ram_init(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEAD_BEEF;
    return {8'hA5, a, 8'h5A, a};
  endfunction

  logic [31:0] ram_arr[256];
  bit          ram_wr[256];

  always @(posedge clk) begin
    if (ram_we) begin
      ram_arr[ram_addr[7:0]] <= ram_wdata;
      ram_wr[ram_addr[7:0]]  <= 1'b1;
    end
    ram_q <= ram_wr[ram_addr[7:0]] ? ram_arr[ram_addr[7:0]] : ram_init(ram_addr[7:0]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.if_ack || bus.mem_ack)) begin
      chk("ack_exclusive", {31'd0, bus.if_ack & bus.mem_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, bus.if_ack}, {31'd0, e.is_if});
        chk("ack_rdata", bus.if_ack ? bus.if_rdata : bus.mem_rdata, e.data);
      end
    end
  end

  task automatic wait_ack(input bit want_if, output int n);
    bit seen;
    seen = 1'b0;
    n    = -1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (want_if ? bus.if_ack : bus.mem_ack) begin
        seen = 1'b1;
        n    = i;
      end
    end
    chk(want_if ? "if_ack_wait" : "mem_ack_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic push(input bit is_if, input logic [31:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;

    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    repeat (3) @(negedge clk);

    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_ram_we",    {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr",  {16'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_if_rdata",  bus.if_rdata, 32'h0000_0013);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
    chk("rst_acks",      {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single IF fetch: address one cycle later, ack three cycles after request.
    bus.if_addr = 16'h0010;
    bus.if_req  = 1'b1;
    push(1'b1, 32'hDEAD_BEEF);
    exp_if = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_ram_addr", {16'd0, ram_addr}, 32'h0000_0010);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_ack(1'b1, n);
    chk("t1_latency", n + 1, 32'd3);
    bus.if_req = 1'b0;

    // Simultaneous requests: MEM first, IF immediately after.
    bus.if_addr  = 16'h0030;
    bus.if_req   = 1'b1;
    bus.mem_addr = 16'h0020;
    bus.mem_we   = 1'b0;
    bus.mem_req  = 1'b1;
    push(1'b0, 32'hA520_5A20);
    push(1'b1, 32'hA530_5A30);
    exp_mem = 32'hA520_5A20;
    exp_if  = 32'hA530_5A30;
    wait_ack(1'b0, n);
    bus.mem_req = 1'b0;
    wait_ack(1'b1, n);
    chk("t2_if_after_mem", n, 32'd3);
    bus.if_req = 1'b0;

    // MEM write: one-cycle strobe, mem_rdata keeps the last read value.
    bus.mem_addr  = 16'h0005;
    bus.mem_wdata = 32'h1234_5678;
    bus.mem_we    = 1'b1;
    bus.mem_req   = 1'b1;
    push(1'b0, exp_mem);
    @(negedge clk);
    chk("t3_ram_we_on", {31'd0, ram_we}, 32'd1);
    chk("t3_ram_addr", {16'd0, ram_addr}, 32'h0000_0005);
    chk("t3_ram_wdata", ram_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("t3_ram_we_off", {31'd0, ram_we}, 32'd0);
    wait_ack(1'b0, n);
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;

    // Fetch the written word back through the IF port.
    bus.if_addr = 16'h0005;
    bus.if_req  = 1'b1;
    push(1'b1, 32'h1234_5678);
    exp_if = 32'h1234_5678;
    wait_ack(1'b1, n);
    bus.if_req = 1'b0;

    // Starvation: MEM back-to-back, IF held; IF wins the fourth decision.
    bus.if_addr  = 16'h0040;
    bus.if_req   = 1'b1;
    bus.mem_addr = 16'h0050;
    bus.mem_req  = 1'b1;
    for (int k = 0; k < 3; k++) push(1'b0, 32'hA550_5A50);
    push(1'b1, 32'hA540_5A40);
    exp_mem = 32'hA550_5A50;
    exp_if  = 32'hA540_5A40;
    for (int k = 0; k < 3; k++) wait_ack(1'b0, n);
    wait_ack(1'b1, n);
    chk("t4_if_fourth", n, 32'd3);
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk);

    // Starvation count cleared: a new tie goes to MEM again.
    bus.if_addr  = 16'h0030;
    bus.if_req   = 1'b1;
    bus.mem_addr = 16'h0020;
    bus.mem_req  = 1'b1;
    push(1'b0, 32'hA520_5A20);
    push(1'b1, 32'hA530_5A30);
    exp_mem = 32'hA520_5A20;
    exp_if  = 32'hA530_5A30;
    wait_ack(1'b0, n);
    bus.mem_req = 1'b0;
    wait_ack(1'b1, n);
    bus.if_req = 1'b0;

    // Flush during IF access: no ack, if_rdata unchanged, normal busy timing.
    bus.if_addr = 16'h0060;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("t5_busy_access", {31'd0, busy}, 32'd1);
    bus.if_flush = 1'b1;
    @(negedge clk);
    bus.if_flush = 1'b0;
    chk("t5_busy_resp", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t5_busy_fall", {31'd0, busy}, 32'd0);
    chk("t5_no_ack", {31'd0, bus.if_ack}, 32'd0);
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_if_rdata_kept", bus.if_rdata, exp_if);

    // Flush seen in IDLE: IF not granted that cycle, granted once flush drops.
    bus.if_addr  = 16'h0010;
    bus.if_req   = 1'b1;
    bus.if_flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_idle", {31'd0, busy}, 32'd0);
    bus.if_flush = 1'b0;
    push(1'b1, 32'hDEAD_BEEF);
    wait_ack(1'b1, n);
    chk("t6_latency", n, 32'd3);
    bus.if_req = 1'b0;

    // Reset during a write's ACCESS cycle: strobe cut, no ack afterwards.
    bus.mem_addr  = 16'h0007;
    bus.mem_wdata = 32'hFEED_F00D;
    bus.mem_we    = 1'b1;
    bus.mem_req   = 1'b1;
    @(negedge clk);
    chk("t7_ram_we_pre", {31'd0, ram_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_ram_we", {31'd0, ram_we}, 32'd0);
    chk("t7_acks", {30'd0, bus.if_ack, bus.mem_ack}, 32'd0);
    chk("t7_if_rdata", bus.if_rdata, 32'h0000_0013);
    chk("t7_ram_addr", {16'd0, ram_addr}, 32'd0);
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t7_idle_after", {31'd0, busy}, 32'd0);

    // The cut write never reached the RAM.
    bus.if_addr = 16'h0007;
    bus.if_req  = 1'b1;
    push(1'b1, 32'hA507_5A07);
    wait_ack(1'b1, n);
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
